// File: rtl/demux2_4b_buf.sv
// rtl/demux2_4b_buf.sv - registered 1-to-2 demux with a 2-entry FIFO per output channel
// Optional delivered-item counters cnt0/cnt1 are built when DEMUX2_COUNT_EN is defined.
module demux2_4b_buf (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic       in_sel,
    input  logic [3:0] in_data,
    output logic       out0_val,
    input  logic       out0_rdy,
    output logic [3:0] out0_data,
    output logic       out1_val,
    input  logic       out1_rdy,
    output logic [3:0] out1_data
`ifdef DEMUX2_COUNT_EN
    ,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
`endif
);

    logic [3:0] mem     [2][2];
    logic [3:0] mem_n   [2][2];
    logic [1:0] count   [2];
    logic [1:0] count_n [2];
    logic [3:0] head_q  [2];
    logic [3:0] head_n  [2];
    logic [1:0] wr_ptr, wr_n;
    logic [1:0] rd_ptr, rd_n;
    logic [1:0] full, enq, deq;

    assign full   = {count[1] == 2'd2, count[0] == 2'd2};
    // Held low during reset so no producer sees a ready that cannot be honoured.
    assign in_rdy = reset & ~full[in_sel];
    assign enq    = {in_val & in_rdy & in_sel, in_val & in_rdy & ~in_sel};
    assign deq    = {(count[1] != 2'd0) & out1_rdy, (count[0] != 2'd0) & out0_rdy};

    // The head register keeps its value once a channel drains, so the data output stays stable.
    always_comb begin
        mem_n   = mem;
        wr_n    = wr_ptr;
        rd_n    = rd_ptr;
        count_n = count;
        head_n  = head_q;
        for (int k = 0; k < 2; k++) begin
            if (enq[k]) begin
                mem_n[k][wr_ptr[k]] = in_data;
                wr_n[k]             = ~wr_ptr[k];
            end
            if (deq[k]) begin
                rd_n[k] = ~rd_ptr[k];
            end
            count_n[k] = count[k] + {1'b0, enq[k]} - {1'b0, deq[k]};
            if (count_n[k] != 2'd0) begin
                head_n[k] = mem_n[k][rd_n[k]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < 2; j++) begin
                    mem[k][j] <= 4'd0;
                end
                count[k]  <= 2'd0;
                head_q[k] <= 4'd0;
            end
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            mem    <= mem_n;
            count  <= count_n;
            head_q <= head_n;
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
        end
    end

    assign out0_val  = (count[0] != 2'd0);
    assign out1_val  = (count[1] != 2'd0);
    assign out0_data = head_q[0];
    assign out1_data = head_q[1];

`ifdef DEMUX2_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0 <= 8'd0;
            cnt1 <= 8'd0;
        end else begin
            if (deq[0]) cnt0 <= cnt0 + 8'd1;
            if (deq[1]) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: doc/demux2_4b_buf.md
# demux2_4b_buf

Registered 1-to-2 demultiplexer for the calculator datapath: accepts one 4-bit value per cycle on a valid/ready input stream and steers it, by a select bit, into one of two output channels. Each channel has its own 2-entry FIFO, so one stalled consumer never corrupts the other's data and never drops a value. The block sits where a single result stream fans out to two consumers, for example the display register and the operand feedback path.

## Interface
- No parameters. Data width is fixed at 4 bits and FIFO depth is fixed at 2 per channel.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; the block is in reset while `reset` is 0.
- `in_val` input 1: input data valid.
- `in_rdy` output 1: block can accept a value for the currently selected channel.
- `in_sel` input 1: destination channel; 0 selects channel 0, 1 selects channel 1.
- `in_data` input 4: input value.
- `out0_val` output 1: channel 0 head entry valid.
- `out0_rdy` input 1: channel 0 consumer ready.
- `out0_data` output 4: channel 0 head entry.
- `out1_val`, `out1_rdy`, `out1_data`: same as channel 0, for channel 1.
- `cnt0`, `cnt1` output 8 each: delivered-item counters; present only with `DEMUX2_COUNT_EN` (see Configuration).

## Operation
- **Enqueue.** Occurs on a rising edge when `in_val & in_rdy`. `in_data` is written to the tail of FIFO[`in_sel`].
- **`in_rdy`.** Combinational, equal to !full(FIFO[`in_sel`]). It depends only on `in_sel` and the FIFO occupancy, never on `in_val`.
- **Dequeue.** Occurs on channel k when `outk_val & outk_rdy` at a rising edge. The head entry is removed.
- **Output signals.**
  - `outk_val` is 1 when occupancy(k) > 0.
  - `outk_data` is the head entry, driven from registers.
  - When a channel is empty, `outk_data` holds its last value. Consumers must ignore it.
- **Occupancy per channel.** 0, 1 or 2, tracked as a 2-bit count with a 1-bit write pointer and a 1-bit read pointer. The pointers wrap from 1 to 0.
- **Ordering.** Each channel is strictly FIFO. There is no ordering guarantee between channels.
- **Bypass.** None. Data enters a FIFO register before it can appear on an output.
- **Boundary cases.**
  - Enqueue and dequeue on the same channel at occupancy 1: occupancy stays 1 and the head advances correctly.
  - Full channel (occupancy 2): `in_rdy` is 0 for that select, even if the consumer dequeues in the same cycle. There is no pass-through when full.
  - Empty channel: dequeue is impossible because `outk_val` is 0. `outk_rdy` is ignored.
  - Input enqueues to channel 0 while channel 1 dequeues: the two operations are fully independent.
  - `in_sel` may change every cycle. Only the value sampled at the accepting edge matters.
- **Reset.**
  - Takes effect immediately when `reset` falls, regardless of `clk`.
  - Clears all occupancies, pointers and storage to 0.
  - During reset: `out0_val` = `out1_val` = 0, `out0_data` = `out1_data` = 4'b0000, `in_rdy` = 0.
  - If reset is asserted mid-operation, all buffered items are discarded.
- **After reset.** On the first cycle after `reset` rises, `in_rdy` = 1.

## Timing
- **Latency.** A value accepted at edge N is visible on `outk_val`/`outk_data` after edge N, i.e. one cycle later, if the channel was empty.
- **Throughput.** One value per cycle per channel. A consumer that is always ready sustains full rate through occupancy 1.
- **Combinational paths.**
  - `in_sel` → `in_rdy` is the only combinational input-to-output path.
  - There is no path from `in_val` or `outk_rdy` to any output.

## Configuration
- **`DEMUX2_COUNT_EN` defined.**
  - Adds outputs `cnt0` and `cnt1`. Each counter increments by 1 on every dequeue of its channel.
  - Counters wrap from 255 to 0. They reset to 0 asynchronously with `reset`.
- **`DEMUX2_COUNT_EN` undefined.** The ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset.**
  - Stimulus: hold `reset`=0 and toggle inputs.
  - Required: `in_rdy`=0, both `outk_val`=0, both `outk_data`=0000.
  - Then release reset with `in_sel`=0. Required: `in_rdy`=1.
- **Basic steer.**
  - Stimulus: enqueue 1010 with sel=0, then 0101 with sel=1; both `outk_rdy`=1.
  - Required: `out0_data`=1010 with `out0_val`=1 for one cycle, then `out1_data`=0101 with `out1_val`=1 for one cycle.
- **Fill and stall.**
  - Stimulus: `out0_rdy`=0; enqueue 0001, 0010 with sel=0.
  - Required: `in_rdy`=0 with sel=0 and `in_rdy`=1 with sel=1.
  - Then set `out0_rdy`=1. Required: outputs 0001 then 0010, then `out0_val`=0.
- **Simultaneous enqueue/dequeue.**
  - Stimulus: channel 1 holds 1100; enqueue 0011 with sel=1 while `out1_rdy`=1.
  - Required: next cycle `out1_data`=0011 with `out1_val`=1.
- **Reset mid-operation.**
  - Stimulus: both channels full (0001/0010 and 1110/1111); pulse `reset`=0 between clock edges.
  - Required: `out0_val`=`out1_val`=0 immediately; nothing is delivered after release.
- **Random.**
  - Stimulus: 200 cycles of random `in_val`, `in_sel`, `in_data`, `out0_rdy`, `out1_rdy`.
  - Required: per-channel output sequences match a reference queue model.
  - With `DEMUX2_COUNT_EN`: `cnt0` and `cnt1` equal the per-channel delivered counts mod 256.
